ide_ctrlblk_mux: RTL

- Parametrised successor to the single-channel 0x3F6 control-block decoder.
- Serves CHANNELS IDE control-block I/O windows (primary 0x3F0–0x3F7, secondary 0x370–0x377, …), each an independent 8-byte Avalon slave.
- Per channel it forwards alternate-status reads and device-control writes to the IDE core.
- Per channel it keeps a device-control shadow register, drives nIEN, and generates a timed soft-reset (SRST) pulse with status override while reset is active.

---
 rtl/ide_ctrlblk_mux.sv | 117 +++++++++++
 1 files changed

// File: rtl/ide_ctrlblk_mux.sv
// Multi-channel IDE control-block decoder: alternate-status reads, device-control
// writes, nIEN shadow and a minimum-length soft-reset pulse per channel.
module ide_ctrlblk_mux #(
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned SRST_MIN_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3*CHANNELS-1:0] io_address,
  input  logic [CHANNELS-1:0]   io_read,
  output logic [8*CHANNELS-1:0] io_readdata,
  input  logic [CHANNELS-1:0]   io_write,
  input  logic [8*CHANNELS-1:0] io_writedata,
  output logic [CHANNELS-1:0]   ide_altstat_read,
  input  logic [8*CHANNELS-1:0] ide_altstat_readdata,
  output logic [CHANNELS-1:0]   ide_devctl_write,
  output logic [8*CHANNELS-1:0] ide_devctl_writedata,
  output logic [CHANNELS-1:0]   ide_srst,
  output logic [CHANNELS-1:0]   ide_nien
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_HOLD   = 2'd2
  } srst_state_e;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SRST_MIN_CYCLES - 1);

  assign ide_devctl_writedata = io_writedata;

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [2:0]       w_addr;
      logic [7:0]       w_wdata;
      logic [7:0]       w_alt;
      logic             w_sel6;
      logic             w_rd_valid;
      logic             w_wr6;
      logic             r_read_last;
      logic [7:0]       r_shadow;
      logic [7:0]       r_rdata;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      srst_state_e      r_state;
      srst_state_e      w_state_nxt;

      assign w_addr     = io_address[3*c +: 3];
      assign w_wdata    = io_writedata[8*c +: 8];
      assign w_alt      = ide_altstat_readdata[8*c +: 8];
      assign w_sel6     = (w_addr == 3'd6);
      assign w_rd_valid = io_read[c] & ~r_read_last;
      assign w_wr6      = io_write[c] & w_sel6;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_read_last <= 1'b0;
          r_shadow    <= '0;
          r_rdata     <= '1;
        end else begin
          r_read_last <= r_read_last ? 1'b0 : io_read[c];
          if (w_wr6) r_shadow <= w_wdata & 8'h06;
          if (w_sel6) r_rdata <= (r_state == S_IDLE) ? w_alt : 8'h80;
          else        r_rdata <= '1;
        end
      end

      // Exit tests use the pre-decrement count so the pulse lasts at least
      // SRST_MIN_CYCLES cycles measured from the asserting write edge.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        case (r_state)
          S_IDLE: begin
            w_cnt_nxt = r_cnt;
            if (w_wr6 && w_wdata[2]) begin
              w_state_nxt = S_ASSERT;
              w_cnt_nxt   = RELOAD;
            end
          end
          S_ASSERT: begin
            if (w_wr6 && !w_wdata[2])
              w_state_nxt = (r_cnt != '0) ? S_HOLD : S_IDLE;
          end
          S_HOLD: begin
            if (w_wr6 && w_wdata[2]) begin
              w_state_nxt = S_ASSERT;
              w_cnt_nxt   = RELOAD;
            end else if (r_cnt == '0) begin
              w_state_nxt = S_IDLE;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      assign io_readdata[8*c +: 8] = r_rdata;
      assign ide_altstat_read[c]   = w_rd_valid & w_sel6 & (r_state == S_IDLE);
      assign ide_devctl_write[c]   = w_wr6;
      assign ide_srst[c]           = (r_state != S_IDLE);
      assign ide_nien[c]           = r_shadow[1];
    end
  endgenerate

endmodule
